// File: rtl/regfile_param_pkg.sv
// regfile_param_pkg: shared defaults and state encoding for the parametrised register file
package regfile_param_pkg;
  localparam int RF_XLEN  = 32;
  localparam int RF_DEPTH = 32;
  typedef enum logic {RF_ST_CLEAR = 1'b0, RF_ST_IDLE = 1'b1} rf_state_e;
endpackage

// File: rtl/regfile_clear_seq.sv
// regfile_clear_seq: sweeps a clear pointer over the array after reset or on request
module regfile_clear_seq
  import regfile_param_pkg::*;
#(
  parameter  int DEPTH = RF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_req,
  output logic          ready,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);
  rf_state_e     state;
  logic [AW-1:0] clr_ptr;
  always_ff @(posedge clk) begin
    if (reset || clear_req) begin
      state   <= RF_ST_CLEAR;
      clr_ptr <= '0;
    end else if (state == RF_ST_CLEAR) begin
      if (clr_ptr == AW'(DEPTH - 1)) state <= RF_ST_IDLE;
      clr_ptr <= clr_ptr + 1'b1;
    end
  end
  assign ready    = state == RF_ST_IDLE;
  assign clr_we   = state == RF_ST_CLEAR;
  assign clr_addr = clr_ptr;
endmodule

// File: rtl/regfile_param.sv
// regfile_param: multi-read-port register file with optional write bypass and clear sequencer
module regfile_param
  import regfile_param_pkg::*;
#(
  parameter  int XLEN     = RF_XLEN,
  parameter  int DEPTH    = RF_DEPTH,
  parameter  int NREAD    = 2,
  parameter  int BYPASS   = 0,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_req,
  output logic                  ready,
  input  logic                  we,
  input  logic [AW-1:0]         wa,
  input  logic [XLEN-1:0]       wd,
  input  logic [NREAD*AW-1:0]   ra,
  output logic [NREAD*XLEN-1:0] rd,
  output logic                  wr_dropped
);
  logic [XLEN-1:0] rf [DEPTH];
  logic            clr_we;
  logic [AW-1:0]   clr_addr;
  logic            wr_ok;
  regfile_clear_seq #(.DEPTH(DEPTH)) u_seq (
    .clk(clk), .reset(reset), .clear_req(clear_req),
    .ready(ready), .clr_we(clr_we), .clr_addr(clr_addr)
  );
  assign wr_ok = we && ready && !(ZERO_REG != 0 && wa == '0);
  // The sweep owns the write port whenever it runs
  always_ff @(posedge clk) begin
    if (clr_we) rf[clr_addr] <= '0;
    else if (wr_ok) rf[wa] <= wd;
  end
  always_ff @(posedge clk) begin
    if (reset) wr_dropped <= 1'b0;
    else if (we && !ready) wr_dropped <= 1'b1;
  end
  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0] a;
    assign a = ra[i*AW +: AW];
    assign rd[i*XLEN +: XLEN] = (!ready || (ZERO_REG != 0 && a == '0)) ? '0 :
                                (BYPASS != 0 && we && wa == a) ? wd : rf[a];
  end
endmodule
